seven_segment_scan_controller: RTL and testbench

Time-multiplexes the shared 8-bit segment bus (abcdefgh) across w_digit common-select lines (digit) of the board's 7-segment display.
- Captures a hex value and dot mask into a shadow register once per frame, so a displayed frame never mixes old and new values.
- Inserts a blanking interval between digit slots to suppress ghosting.
- Sits between the design's value producer (e.g. a CPU result register) and the top-level uo_out/uio_out pins.

---
 rtl/seven_segment_scan_controller_if.sv | 39 +++
 rtl/seven_segment_scan_controller.sv | 170 +++++++++++++++++
 tb/tb_seven_segment_scan_controller.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/seven_segment_scan_controller_if.sv
// ============================================================================
// Module      : seven_segment_scan_controller_if
// Description : Bundles the value-producer side and the display-pin side of
//               the 7-segment scan controller.
//               master : value producer (drives number/dots/digit_en and
//                        observes frame_start and the display pins)
//               slave  : scan controller
//   number      [4*W_DIGIT] hex nibbles, nibble i drives digit i
//   dots        [W_DIGIT]   decimal point per digit
//   digit_en    [W_DIGIT]   per-digit enable, 0 keeps the digit dark
//   frame_start [1]         one-cycle pulse when the shadow registers load
//   abcdefgh    [8]         segments, active high, bit7 = a, bit0 = dot
//   digit       [W_DIGIT]   one-hot digit select, active high
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seven_segment_scan_controller_if #(
  parameter int W_DIGIT = 8
);
  logic [4*W_DIGIT-1:0] number;
  logic [W_DIGIT-1:0]   dots;
  logic [W_DIGIT-1:0]   digit_en;
  logic                 frame_start;
  logic [7:0]           abcdefgh;
  logic [W_DIGIT-1:0]   digit;

  modport master (
    output number, dots, digit_en,
    input  frame_start, abcdefgh, digit
  );

  modport slave (
    input  number, dots, digit_en,
    output frame_start, abcdefgh, digit
  );
endinterface

`default_nettype wire

// File: rtl/seven_segment_scan_controller.sv
// ============================================================================
// Module      : seven_segment_scan_controller
// Description : Time-multiplexes one 8-bit segment bus across W_DIGIT digit
//               select lines. Each digit slot is SLOT_CYCLES long and starts
//               with BLANK_CYCLES of all-dark outputs to suppress ghosting.
//               The displayed values are taken from a shadow register loaded
//               once per frame, so a frame never mixes old and new values.
// Ports       : clk    - clock
//               rst_n  - asynchronous active-low reset
//               bus    - seven_segment_scan_controller_if.slave
//                        (number/dots/digit_en in; frame_start/abcdefgh/
//                        digit out, all outputs registered)
// Options     : define SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN to blank leading
//               zero digits (a set dot stops the blanking at its position).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module seven_segment_scan_controller #(
  parameter int W_DIGIT      = 8,
  parameter int SLOT_CYCLES  = 50000,
  parameter int BLANK_CYCLES = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  seven_segment_scan_controller_if.slave   bus
);

  localparam int CNT_W = $clog2(SLOT_CYCLES);
  localparam int IDX_W = (W_DIGIT > 1) ? $clog2(W_DIGIT) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SLOT_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SHOW = CNT_W'(BLANK_CYCLES);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(W_DIGIT - 1);

  typedef enum logic [0:0] {
    ST_BLANK = 1'b0,
    ST_SHOW  = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [4*W_DIGIT-1:0]  num_q;
  logic [W_DIGIT-1:0]    dots_q;
  logic [W_DIGIT-1:0]    en_q;
  logic                  fs_q;
  logic [7:0]            seg_q, seg_d;
  logic [W_DIGIT-1:0]    digit_q, digit_d;
  logic [W_DIGIT-1:0]    supp_mask;
  logic                  cnt_wrap;
  logic                  load;

  function automatic logic [6:0] hex7(input logic [3:0] v);
    logic [6:0] s;
    case (v)
      4'h0: s = 7'b1111110;
      4'h1: s = 7'b0110000;
      4'h2: s = 7'b1101101;
      4'h3: s = 7'b1111001;
      4'h4: s = 7'b0110011;
      4'h5: s = 7'b1011011;
      4'h6: s = 7'b1011111;
      4'h7: s = 7'b1110000;
      4'h8: s = 7'b1111111;
      4'h9: s = 7'b1111011;
      4'hA: s = 7'b1110111;
      4'hB: s = 7'b0011111;
      4'hC: s = 7'b1001110;
      4'hD: s = 7'b0111101;
      4'hE: s = 7'b1001111;
      default: s = 7'b1000111;
    endcase
    return s;
  endfunction

  assign cnt_wrap = (cnt_q == CNT_LAST);
  // Counter and index are both zero on the first edge after reset and at the
  // start of every frame, so one condition covers both load cases.
  assign load     = (cnt_q == '0) && (idx_q == '0);

  // Counters and FSM next state
  always_comb begin
    cnt_d   = cnt_wrap ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    state_d = state_q;
    if (cnt_wrap) begin
      idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
    end
    case (state_q)
      ST_BLANK: if (cnt_d == CNT_SHOW) state_d = ST_SHOW;
      ST_SHOW:  if (cnt_wrap)          state_d = ST_BLANK;
      default:  state_d = ST_BLANK;
    endcase
  end

  // Output decode from the current slot; registered below, hence the
  // one-cycle lag between counter value and visible output.
  always_comb begin
    digit_d = '0;
    seg_d   = '0;
    if ((state_q == ST_SHOW) && en_q[idx_q] && !supp_mask[idx_q]) begin
      digit_d[idx_q] = 1'b1;
      seg_d          = {hex7(num_q[{idx_q, 2'b00} +: 4]), dots_q[idx_q]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_BLANK;
      cnt_q   <= '0;
      idx_q   <= '0;
      num_q   <= '0;
      dots_q  <= '0;
      en_q    <= '0;
      fs_q    <= 1'b0;
      seg_q   <= '0;
      digit_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      fs_q    <= load;
      seg_q   <= seg_d;
      digit_q <= digit_d;
      if (load) begin
        num_q  <= bus.number;
        dots_q <= bus.dots;
        en_q   <= bus.digit_en;
      end
    end
  end

`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
  logic [W_DIGIT-1:0] supp_q, supp_d;

  // Walk from the most significant digit down; a digit is blanked while
  // everything from it upward is a zero nibble without a dot. Digit 0 is
  // always shown. Computed from the values being loaded so the mask is
  // valid together with the shadow register.
  always_comb begin
    logic all_zero;
    all_zero = 1'b1;
    supp_d   = '0;
    for (int i = W_DIGIT - 1; i >= 0; i--) begin
      all_zero = all_zero && (bus.number[4*i +: 4] == 4'h0) && !bus.dots[i];
      if (i != 0) supp_d[i] = all_zero;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      supp_q <= '0;
    end else if (load) begin
      supp_q <= supp_d;
    end
  end

  assign supp_mask = supp_q;
`else
  assign supp_mask = '0;
`endif

  assign bus.frame_start = fs_q;
  assign bus.abcdefgh    = seg_q;
  assign bus.digit       = digit_q;

endmodule

`default_nettype wire

// File: tb/tb_seven_segment_scan_controller.sv
// ============================================================================
// Module      : tb_seven_segment_scan_controller
// Description : Self-checking bench for seven_segment_scan_controller with
//               W_DIGIT = 8, SLOT_CYCLES = 8, BLANK_CYCLES = 2. A reference
//               model derives the expected outputs from the number of clock
//               edges since reset release and the values captured per frame.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_seven_segment_scan_controller;

  localparam int W     = 8;
  localparam int SLOT  = 8;
  localparam int BLANK = 2;
  localparam int FRAME = W * SLOT;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  seven_segment_scan_controller_if #(.W_DIGIT(W)) bus_if ();

  seven_segment_scan_controller #(
    .W_DIGIT      (W),
    .SLOT_CYCLES  (SLOT),
    .BLANK_CYCLES (BLANK)
  ) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if.slave)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [6:0] seg_tab [16];
  int          e      = 0;     // clock edges since reset release
  logic [31:0] m_num  = '0;
  logic [7:0]  m_dots = '0;
  logic [7:0]  m_en   = '0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e      <= 0;
      m_num  <= '0;
      m_dots <= '0;
      m_en   <= '0;
    end else begin
      if (e % FRAME == 0) begin
        m_num  <= bus_if.number;
        m_dots <= bus_if.dots;
        m_en   <= bus_if.digit_en;
      end
      e <= e + 1;
    end
  end

  function automatic logic suppressed(input int s);
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    return (s != 0) && ((m_num >> (4 * s)) == 0) && ((m_dots >> s) == 0);
`else
    return (s < 0);
`endif
  endfunction

  task automatic model_out(output logic fs, output logic [7:0] dg, output logic [7:0] sg);
    int pos, c, s;
    logic [3:0] nib;
    fs = 1'b0;
    dg = '0;
    sg = '0;
    if (e > 0) begin
      pos = e - 1;
      c   = pos % SLOT;
      s   = (pos / SLOT) % W;
      fs  = (pos % FRAME == 0);
      if (c >= BLANK && m_en[s] && !suppressed(s)) begin
        nib = 4'(m_num >> (4 * s));
        dg  = 8'(1 << s);
        sg  = {seg_tab[nib], m_dots[s]};
      end
    end
  endtask

  always @(negedge clk) begin
    logic       x_fs;
    logic [7:0] x_dg, x_sg;
    model_out(x_fs, x_dg, x_sg);
    check_eq("frame_start", 32'(bus_if.frame_start), 32'(x_fs));
    check_eq("digit",       32'(bus_if.digit),       32'(x_dg));
    check_eq("abcdefgh",    32'(bus_if.abcdefgh),    32'(x_sg));
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_e(input int target);
    int guard = 0;
    while (e != target && guard < 4 * FRAME) begin
      @(negedge clk);
      guard++;
    end
    if (e != target) check_eq("wait_timeout", 32'(e), 32'(target));
  endtask

  task automatic set_in(input logic [31:0] n, input logic [7:0] d, input logic [7:0] en);
    bus_if.number   = n;
    bus_if.dots     = d;
    bus_if.digit_en = en;
  endtask

  task automatic random_run(input int cycles);
    repeat (cycles) begin
      @(negedge clk);
      if ($urandom_range(0, 30) == 0) begin
        set_in($urandom >> $urandom_range(0, 31),
               ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00,
               ($urandom_range(0, 1) == 0) ? 8'hFF : 8'($urandom));
      end
    end
  endtask

  task automatic check_pins(input string tag, input logic [7:0] dg, input logic [7:0] sg);
    check_eq({tag, "_digit"}, 32'(bus_if.digit), 32'(dg));
    check_eq({tag, "_seg"},   32'(bus_if.abcdefgh), 32'(sg));
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int target;
    seg_tab[0]  = 7'b1111110; seg_tab[1]  = 7'b0110000;
    seg_tab[2]  = 7'b1101101; seg_tab[3]  = 7'b1111001;
    seg_tab[4]  = 7'b0110011; seg_tab[5]  = 7'b1011011;
    seg_tab[6]  = 7'b1011111; seg_tab[7]  = 7'b1110000;
    seg_tab[8]  = 7'b1111111; seg_tab[9]  = 7'b1111011;
    seg_tab[10] = 7'b1110111; seg_tab[11] = 7'b0011111;
    seg_tab[12] = 7'b1001110; seg_tab[13] = 7'b0111101;
    seg_tab[14] = 7'b1001111; seg_tab[15] = 7'b1000111;

    // Reset and first load
    set_in(32'h0123_4567, 8'h00, 8'hFF);
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check_pins("in_reset", 8'h00, 8'h00);
    rst_n = 1'b1;

    // Basic display
    wait_e(1);  check_eq("fs_first", 32'(bus_if.frame_start), 32'd1);
    wait_e(2);  check_pins("slot0_blank", 8'h00, 8'h00);
    wait_e(4);  check_pins("slot0_show", 8'h01, 8'hE0);
    // nibble 3 of 0x01234567 is 4
    wait_e(29); check_pins("slot3_show", 8'h08, 8'h66);

    // No tearing: change during slot 4
    wait_e(34); set_in(32'hFFFF_FFFF, 8'h00, 8'hFF);
    wait_e(37); check_pins("slot4_old", 8'h10, 8'hF2);
`ifdef SEVEN_SEGMENT_LEADING_ZERO_BLANK_EN
    wait_e(61); check_pins("slot7_old", 8'h00, 8'h00);
`else
    wait_e(61); check_pins("slot7_old", 8'h80, 8'hFC);
`endif
    wait_e(65); check_eq("fs_second", 32'(bus_if.frame_start), 32'd1);
    wait_e(84); check_pins("slot2_new", 8'h04, 8'h8E);

    // Disabled digit and dot
    wait_e(100); set_in(32'h8888_8888, 8'h01, 8'hF7);
    wait_e(129); check_eq("fs_third", 32'(bus_if.frame_start), 32'd1);
    wait_e(132); check_pins("dot_slot0", 8'h01, 8'hFF);
    wait_e(157); check_pins("dis_slot3", 8'h00, 8'h00);
    wait_e(164); check_pins("slot4_8", 8'h10, 8'hFE);
    wait_e(193); check_eq("fs_len", 32'(bus_if.frame_start), 32'd1);

    // Randomized traffic
    random_run(6 * FRAME);

    // Asynchronous reset during slot 2 SHOW
    set_in(32'h1234_5678, 8'h00, 8'hFF);
    target = ((e - 1) / FRAME + 2) * FRAME + 2 * SLOT + 5;
    wait_e(target);
    check_pins("pre_reset", 8'h04, 8'hBE);
    #2 rst_n = 1'b0;
    #1 check_pins("async_reset", 8'h00, 8'h00);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    wait_e(1);  check_eq("fs_restart", 32'(bus_if.frame_start), 32'd1);
    wait_e(2);  check_pins("restart_blank", 8'h00, 8'h00);
    wait_e(4);  check_pins("restart_slot0", 8'h01, 8'hFE);

    // Leading-zero patterns
    set_in(32'h0000_0042, 8'h00, 8'hFF);
    random_run(0);
    wait_e(FRAME + 1);
    wait_e(2 * FRAME + 1);
    set_in(32'h0000_0042, 8'h20, 8'hFF);
    wait_e(3 * FRAME + 1);
    wait_e(4 * FRAME + 1);

    random_run(3 * FRAME);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
